// File: rtl/multiplier_responder_pkg.sv
// multiplier_responder_pkg: state encoding and default width shared with the factorial controller
package multiplier_responder_pkg;
   localparam int DEFAULT_WIDTH = 64;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;
endpackage

// File: rtl/multiplier_responder_add_cout.sv
// add_cout: WIDTH-bit unsigned adder with carry-out
module add_cout
   import multiplier_responder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/multiplier_responder.sv
// multiplier_responder: sequential shift-add multiplier, one step per cycle, level done handshake
module multiplier_responder
   import multiplier_responder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               opstart,
   input  logic               opclear,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] result,
   output logic               opdone
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   add_b, sum;
   logic               cout;
   logic               last;
   assign last  = cnt_q == CW'(WIDTH);
   assign add_b = b_q[0] ? a_q : '0;
   add_cout #(.WIDTH(WIDTH)) u_add (
      .a   (acc_q[2*WIDTH-1:WIDTH]),
      .b   (add_b),
      .sum (sum),
      .cout(cout)
   );
   always_comb begin
      state_d = state_q;
      if (opclear)
         state_d = IDLE;
      else
         case (state_q)
            IDLE:    state_d = opstart ? EXEC : IDLE;
            EXEC:    state_d = last ? DONE : EXEC;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      done_d = state_d == DONE;
   end
   // the extra cycle at cnt==WIDTH with no step gives the WIDTH+1 latency to opdone
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (opclear || (state_q != IDLE && state_q != EXEC && state_q != DONE)) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == IDLE && opstart) begin
         a_d   = multiplicand;
         b_d   = multiplier;
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == EXEC && !last) begin
         acc_d = {cout, sum, acc_q[WIDTH-1:1]};
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
   assign result = acc_q;
   assign opdone = done_q;
endmodule

// File: tb/tb_multiplier_responder.sv
// tb_multiplier_responder: directed vector table plus handshake corner sequences
module tb_multiplier_responder;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         opstart = 1'b0;
   logic         opclear = 1'b0;
   logic [63:0]  multiplicand = '0;
   logic [63:0]  multiplier = '0;
   logic [127:0] result;
   logic         opdone;
   int           total = 0;
   int           bad = 0;

   typedef struct {
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] p;
   } vec_t;

   multiplier_responder #(.WIDTH(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .opstart     (opstart),
      .opclear     (opclear),
      .multiplicand(multiplicand),
      .multiplier  (multiplier),
      .result      (result),
      .opdone      (opdone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      opstart      = 1'b1;
      @(posedge clk);
      #1 opstart = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      opclear = 1'b1;
      @(posedge clk);
      #1 opclear = 1'b0;
   endtask

   // counts edges after the start edge until opdone rises, bounded
   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (!opdone && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic watch(input int n, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 if (opdone) seen = 1'b1;
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   lat;
      bit   seen;
      vecs[0] = '{64'd3, 64'd5, 128'd15};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
      vecs[2] = '{64'd0, 64'h1234, 128'd0};
      vecs[3] = '{64'd1, 64'h1234, 128'h1234};
      vecs[4] = '{64'd7, 64'd6, 128'd42};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
      vecs[6] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
      vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_result", result, 128'd0);
      check("reset_opdone", {127'd0, opdone}, 128'd0);

      foreach (vecs[i]) begin
         pulse_start(vecs[i].a, vecs[i].b);
         wait_done(0, lat);
         check($sformatf("v%0d_latency", i), 128'(lat), 128'd65);
         check($sformatf("v%0d_result", i), result, vecs[i].p);
         pulse_clear();
         check($sformatf("v%0d_clr_result", i), result, 128'd0);
         check($sformatf("v%0d_clr_opdone", i), {127'd0, opdone}, 128'd0);
      end

      pulse_start(64'd3, 64'd5);
      wait_done(0, lat);
      check("hold_latency", 128'(lat), 128'd65);
      repeat (20) @(posedge clk);
      #1 check("hold_result", result, 128'd15);
      check("hold_opdone", {127'd0, opdone}, 128'd1);
      pulse_start(64'd100, 64'd100);
      repeat (70) @(posedge clk);
      #1 check("done_start_result", result, 128'd15);
      check("done_start_opdone", {127'd0, opdone}, 128'd1);
      pulse_clear();
      check("hold_clr_result", result, 128'd0);

      pulse_start(64'd7, 64'd6);
      repeat (9) @(posedge clk);
      pulse_clear();
      check("abort_result", result, 128'd0);
      watch(80, seen);
      check("abort_no_opdone", {127'd0, seen}, 128'd0);
      check("abort_idle_result", result, 128'd0);

      pulse_start(64'd7, 64'd6);
      repeat (2) @(posedge clk);
      @(negedge clk);
      multiplicand = 64'd9;
      multiplier   = 64'd9;
      opstart      = 1'b1;
      @(posedge clk);
      #1 opstart = 1'b0;
      wait_done(3, lat);
      check("change_latency", 128'(lat), 128'd65);
      check("change_result", result, 128'd42);
      pulse_clear();

      @(negedge clk);
      multiplicand = 64'd5;
      multiplier   = 64'd5;
      opstart      = 1'b1;
      opclear      = 1'b1;
      @(posedge clk);
      #1 opstart = 1'b0;
      opclear = 1'b0;
      watch(80, seen);
      check("both_no_opdone", {127'd0, seen}, 128'd0);
      check("both_result", result, 128'd0);

      pulse_start(64'd11, 64'd13);
      repeat (29) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("exec_reset_result", result, 128'd0);
      check("exec_reset_opdone", {127'd0, opdone}, 128'd0);
      watch(80, seen);
      check("exec_reset_no_opdone", {127'd0, seen}, 128'd0);

      pulse_clear();
      check("idle_clear_result", result, 128'd0);
      check("idle_clear_opdone", {127'd0, opdone}, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
